// File: rtl/ppm_pkg.sv
// Shared types, default timing and the width clamp for the PPM frame scheduler.
package ppm_pkg;

    // Default timing for a 100 MHz clock
    localparam int CNT_W_DEF       = 32;
    localparam int NUM_CH_DEF      = 6;
    localparam int PULSE_LOW_DEF   = 40000;     // 0.4 ms
    localparam int MIN_CH_DEF      = 100000;    // 1 ms
    localparam int MAX_CH_DEF      = 200000;    // 2 ms
    localparam int FRAME_TICKS_DEF = 2000000;   // 20 ms
    localparam int SYNC_MIN_DEF    = 300000;    // 3 ms

    typedef logic [CNT_W_DEF-1:0] ch_width_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CH_LO  = 3'd1,
        ST_CH_HI  = 3'd2,
        ST_END_LO = 3'd3,
        ST_SYNC   = 3'd4
    } ppm_state_t;

    // Unsigned clamp of a channel width into [lo, hi]
    function automatic ch_width_t clamp_width(input ch_width_t value,
                                              input ch_width_t lo,
                                              input ch_width_t hi);
        if (value < lo) begin
            return lo;
        end else if (value > hi) begin
            return hi;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/ppm_frame_scheduler_src_latch.sv
// Source selection, clamping and shadow registers for the channel widths.
// The shadow set only changes on a latch pulse, so a frame in flight always
// sees a consistent set of widths.
module ppm_src_latch
    import ppm_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int MIN_CH = MIN_CH_DEF,
    parameter int MAX_CH = MAX_CH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    latch,
    input  logic                    sw_mode,
    input  logic [NUM_CH*CNT_W-1:0] sw_ch,
    input  logic [NUM_CH*CNT_W-1:0] cap_ch,
    input  logic                    cap_valid,
    output logic [NUM_CH*CNT_W-1:0] shadow,
    output logic                    stale
);

    localparam ch_width_t MIN_W = ch_width_t'(MIN_CH);
    localparam ch_width_t MAX_W = ch_width_t'(MAX_CH);

    logic                    cap_fresh;
    logic                    take_new;
    logic [NUM_CH*CNT_W-1:0] src;
    logic [NUM_CH*CNT_W-1:0] clamped;

    // A capture strobe coinciding with the latch counts as fresh data
    assign take_new = sw_mode | cap_fresh | cap_valid;
    assign src      = sw_mode ? sw_ch : cap_ch;

    // Clamp every channel of the selected source
    always_comb begin
        clamped = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            clamped[k*CNT_W +: CNT_W] = clamp_width(src[k*CNT_W +: CNT_W], MIN_W, MAX_W);
        end
    end

    // Shadow widths, capture freshness and stale flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow[k*CNT_W +: CNT_W] <= MIN_W;
            end
            cap_fresh <= 1'b0;
            stale     <= 1'b0;
        end else if (latch) begin
            if (take_new) begin
                shadow <= clamped;
            end
            stale     <= ~take_new;
            cap_fresh <= 1'b0;
        end else if (cap_valid) begin
            cap_fresh <= 1'b1;
        end
    end

endmodule

// File: rtl/ppm_frame_scheduler.sv
// PPM output sequencer: latches clamped widths at each frame boundary, emits
// low pulse / high remainder per channel, a closing low pulse and a sync gap
// padded to the nominal frame period.
module ppm_frame_scheduler
    import ppm_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PULSE_LOW   = PULSE_LOW_DEF,
    parameter int MIN_CH      = MIN_CH_DEF,
    parameter int MAX_CH      = MAX_CH_DEF,
    parameter int FRAME_TICKS = FRAME_TICKS_DEF,
    parameter int SYNC_MIN    = SYNC_MIN_DEF
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic                    enable,
    input  logic                    sw_mode,
    input  logic [NUM_CH*CNT_W-1:0] sw_ch,
    input  logic [NUM_CH*CNT_W-1:0] cap_ch,
    input  logic                    cap_valid,
    output logic                    ppm_out,
    output logic                    frame_start,
    output logic                    frame_done,
    output logic                    busy,
    output logic [2:0]              cur_ch,
    output logic                    stale
);

    localparam logic [CNT_W-1:0] ONE_W  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PL_W   = CNT_W'(PULSE_LOW);
    localparam logic [CNT_W-1:0] FT_W   = CNT_W'(FRAME_TICKS);
    // A zero-length gap would underflow the down-counter
    localparam logic [CNT_W-1:0] SMIN_W = CNT_W'((SYNC_MIN < 1) ? 1 : SYNC_MIN);
    localparam logic [2:0]       LAST_CH = 3'(NUM_CH - 1);

    ppm_state_t              state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [CNT_W-1:0]        elapsed, elapsed_inc;
    logic [CNT_W-1:0]        cur_w, hi_len, gap;
    logic [2:0]              cur_ch_nx;
    logic                    frame_start_nx;
    logic                    latch;
    logic                    last;
    logic [NUM_CH*CNT_W-1:0] shadow;

    ppm_src_latch #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .MIN_CH (MIN_CH),
        .MAX_CH (MAX_CH)
    ) u_src_latch (
        .clk       (s00_axi_aclk),
        .rst_n     (s00_axi_aresetn),
        .latch     (latch),
        .sw_mode   (sw_mode),
        .sw_ch     (sw_ch),
        .cap_ch    (cap_ch),
        .cap_valid (cap_valid),
        .shadow    (shadow),
        .stale     (stale)
    );

    // Segment lengths: channel high remainder and the sync gap.
    // The gap compares before subtracting so it never wraps.
    always_comb begin
        cur_w       = shadow[cur_ch*CNT_W +: CNT_W];
        hi_len      = (cur_w > PL_W) ? (cur_w - PL_W) : ONE_W;
        elapsed_inc = (elapsed == '1) ? elapsed : (elapsed + ONE_W);
        gap         = SMIN_W;
        if ((FT_W > elapsed_inc) && ((FT_W - elapsed_inc) > SMIN_W)) begin
            gap = FT_W - elapsed_inc;
        end
    end

    assign last = (cnt == '0);

    // Next-state, counter reload and latch request
    always_comb begin
        state_nx       = state;
        cnt_nx         = last ? cnt : (cnt - ONE_W);
        cur_ch_nx      = cur_ch;
        frame_start_nx = 1'b0;
        latch          = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (enable) begin
                    latch          = 1'b1;
                    frame_start_nx = 1'b1;
                    cur_ch_nx      = '0;
                    cnt_nx         = PL_W - ONE_W;
                    state_nx       = ST_CH_LO;
                end
            end
            ST_CH_LO: begin
                if (last) begin
                    cnt_nx   = hi_len - ONE_W;
                    state_nx = ST_CH_HI;
                end
            end
            ST_CH_HI: begin
                if (last) begin
                    cnt_nx = PL_W - ONE_W;
                    if (cur_ch == LAST_CH) begin
                        state_nx = ST_END_LO;
                    end else begin
                        cur_ch_nx = cur_ch + 3'd1;
                        state_nx  = ST_CH_LO;
                    end
                end
            end
            ST_END_LO: begin
                if (last) begin
                    cnt_nx   = gap - ONE_W;
                    state_nx = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (last) begin
                    cur_ch_nx = '0;
                    if (enable) begin
                        latch          = 1'b1;
                        frame_start_nx = 1'b1;
                        cnt_nx         = PL_W - ONE_W;
                        state_nx       = ST_CH_LO;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                cnt_nx    = '0;
                cur_ch_nx = '0;
                state_nx  = ST_IDLE;
            end
        endcase
    end

    // FSM state, segment counter, channel index and frame_start strobe
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cur_ch      <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            cur_ch      <= cur_ch_nx;
            frame_start <= frame_start_nx;
        end
    end

    // Saturating count of frame cycles spent before SYNC
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            elapsed <= '0;
        end else if (latch) begin
            elapsed <= '0;
        end else if ((state == ST_CH_LO) || (state == ST_CH_HI) || (state == ST_END_LO)) begin
            elapsed <= elapsed_inc;
        end
    end

    // Pin is low only during pulses, so reset drives it high at once
    assign ppm_out    = ~((state == ST_CH_LO) || (state == ST_END_LO));
    assign frame_done = (state == ST_SYNC) && last;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ppm_frame_scheduler.sv
// Bench for ppm_frame_scheduler: two instances (nominal and short frame
// period) share inputs; a stimulus process plans frames and pushes expected
// frames into a queue, a monitor measures the pin and compares.
module tb_ppm_frame_scheduler;

    localparam int NCH   = 4;
    localparam int PL    = 4;
    localparam int MINC  = 10;
    localparam int MAXC  = 20;
    localparam int FT_A  = 200;
    localparam int FT_B  = 60;
    localparam int SMIN  = 30;
    localparam int LIMIT = 5000;

    typedef struct packed {
        logic            sw_mode;
        logic            cap_strobe;
        logic            cap_at_latch;
        logic [3:0][31:0] sw;
        logic [3:0][31:0] cap;
    } frame_cfg_t;

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [31:0]      g;
        logic [31:0]      period;
        logic             stale;
        logic             more;
    } frame_exp_t;

    // ---------------- clock / reset / signals ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         sw_mode;
    logic [127:0] sw_ch;
    logic [127:0] cap_ch;
    logic         cap_valid;
    logic         sel;
    logic         mon_en;
    logic         en_a, en_b;

    logic       ppm_a, fs_a, fd_a, busy_a, stale_a;
    logic [2:0] ch_a;
    logic       ppm_b, fs_b, fd_b, busy_b, stale_b;
    logic [2:0] ch_b;

    logic       m_ppm, m_frame_start, m_frame_done, m_busy, m_stale;
    logic [2:0] m_cur_ch;

    always #5 clk = ~clk;

    assign en_a = enable & ~sel;
    assign en_b = enable & sel;

    assign m_ppm         = sel ? ppm_b  : ppm_a;
    assign m_frame_start = sel ? fs_b   : fs_a;
    assign m_frame_done  = sel ? fd_b   : fd_a;
    assign m_busy        = sel ? busy_b : busy_a;
    assign m_stale       = sel ? stale_b : stale_a;
    assign m_cur_ch      = sel ? ch_b   : ch_a;

    ppm_frame_scheduler #(
        .NUM_CH(NCH), .CNT_W(32), .PULSE_LOW(PL), .MIN_CH(MINC), .MAX_CH(MAXC),
        .FRAME_TICKS(FT_A), .SYNC_MIN(SMIN)
    ) dut_a (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .enable(en_a), .sw_mode(sw_mode),
        .sw_ch(sw_ch), .cap_ch(cap_ch), .cap_valid(cap_valid), .ppm_out(ppm_a),
        .frame_start(fs_a), .frame_done(fd_a), .busy(busy_a), .cur_ch(ch_a), .stale(stale_a)
    );

    ppm_frame_scheduler #(
        .NUM_CH(NCH), .CNT_W(32), .PULSE_LOW(PL), .MIN_CH(MINC), .MAX_CH(MAXC),
        .FRAME_TICKS(FT_B), .SYNC_MIN(SMIN)
    ) dut_b (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .enable(en_b), .sw_mode(sw_mode),
        .sw_ch(sw_ch), .cap_ch(cap_ch), .cap_valid(cap_valid), .ppm_out(ppm_b),
        .frame_start(fs_b), .frame_done(fd_b), .busy(busy_b), .cur_ch(ch_b), .stale(stale_b)
    );

    // ---------------- scoreboard state ----------------
    frame_exp_t exp_q[$];
    frame_cfg_t plan_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_sh[2][4];
    bit         m_fresh[2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clampm(input int v);
        if (v < MINC) return MINC;
        if (v > MAXC) return MAXC;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NCH; k++) m_sh[d][k] = MINC;
            m_fresh[d] = 1'b0;
        end
    endtask

    // Expected frame from the latch rules; period from the closed-form max()
    task automatic model_latch(input frame_cfg_t c, input bit more);
        int d, ft, sum, g;
        frame_exp_t e;
        d  = sel ? 1 : 0;
        ft = sel ? FT_B : FT_A;
        e  = '0;
        if (c.sw_mode) begin
            for (int k = 0; k < NCH; k++) m_sh[d][k] = clampm(int'(c.sw[k]));
        end else if (m_fresh[d] || c.cap_at_latch) begin
            for (int k = 0; k < NCH; k++) m_sh[d][k] = clampm(int'(c.cap[k]));
        end else begin
            e.stale = 1'b1;
        end
        m_fresh[d] = 1'b0;
        if (c.cap_at_latch) m_fresh[1-d] = 1'b1;
        sum = 0;
        for (int k = 0; k < NCH; k++) begin
            e.w[k] = m_sh[d][k];
            sum += m_sh[d][k];
        end
        g = ft - (sum + PL);
        if (g < SMIN) g = SMIN;
        e.g      = g;
        e.period = (ft > sum + PL + SMIN) ? ft : (sum + PL + SMIN);
        e.more   = more;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic frame_cfg_t mk_sw(input int a, input int b, input int c, input int d);
        frame_cfg_t f;
        f = '0;
        f.sw_mode = 1'b1;
        f.sw[0] = a; f.sw[1] = b; f.sw[2] = c; f.sw[3] = d;
        return f;
    endfunction

    function automatic frame_cfg_t mk_relay(input bit strobe, input bit at_latch,
                                            input int a, input int b, input int c, input int d);
        frame_cfg_t f;
        f = '0;
        f.cap_strobe   = strobe;
        f.cap_at_latch = at_latch;
        f.cap[0] = a; f.cap[1] = b; f.cap[2] = c; f.cap[3] = d;
        return f;
    endfunction

    function automatic frame_cfg_t mk_rand();
        frame_cfg_t f;
        f = '0;
        f.sw_mode    = 1'($urandom_range(0, 1));
        f.cap_strobe = 1'($urandom_range(0, 1));
        for (int k = 0; k < NCH; k++) begin
            f.sw[k]  = $urandom_range(0, 30);
            f.cap[k] = $urandom_range(0, 30);
        end
        return f;
    endfunction

    // Advance at least one cycle, then wait (bounded) for frame_start
    task automatic wait_start();
        int i;
        @(negedge clk);
        i = 0;
        while (!m_frame_start && i < LIMIT) begin
            @(negedge clk);
            i++;
        end
        cap_valid = 1'b0;
        check("frame_start_seen", int'(m_frame_start), 1);
    endtask

    task automatic wait_idle();
        int i, starts;
        i = 0;
        while ((exp_q.size() != 0 || m_busy) && i < LIMIT) begin
            @(negedge clk);
            i++;
        end
        check("drain_queue", exp_q.size(), 0);
        starts = 0;
        repeat (30) begin
            @(negedge clk);
            if (m_frame_start) starts++;
        end
        check("no_restart", starts, 0);
        check("idle_pin_high", int'(m_ppm), 1);
    endtask

    // Inputs for frame i+1 are applied right after frame i starts, so every
    // change lands mid-frame and must wait for the next latch.
    task automatic run_plan(input bit drop_in_ch1_hi);
        int n, i;
        frame_cfg_t c;
        n = plan_q.size();
        for (int f = 0; f < n; f++) begin
            if (f > 0) wait_start();
            c = plan_q[f];
            sw_mode = c.sw_mode;
            sw_ch   = c.sw;
            cap_ch  = c.cap;
            if (c.cap_strobe) begin
                cap_valid = 1'b1;
                @(negedge clk);
                cap_valid  = 1'b0;
                m_fresh[0] = 1'b1;
                m_fresh[1] = 1'b1;
            end
            model_latch(c, f < n - 1);
            if (f == 0) begin
                if (c.cap_at_latch) cap_valid = 1'b1;
                enable = 1'b1;
            end
        end
        wait_start();
        if (drop_in_ch1_hi) begin
            i = 0;
            while (!(m_cur_ch == 3'd1 && m_ppm) && i < LIMIT) begin
                @(negedge clk);
                i++;
            end
            check("reached_ch1_high", int'(m_cur_ch == 3'd1 && m_ppm), 1);
        end else begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        enable = 1'b0;
        plan_q.delete();
        wait_idle();
    endtask

    // ---------------- monitor ----------------
    task automatic do_frame();
        frame_exp_t e;
        int n, total;
        bit done_seen;
        time t0;
        t0 = $time;
        if (exp_q.size() == 0) begin
            check("frame_expected", 0, 1);
            @(negedge clk);
            return;
        end
        e = exp_q.pop_front();
        check("stale", int'(m_stale), int'(e.stale));
        total = 0;
        for (int k = 0; k < NCH; k++) begin
            check("cur_ch", int'(m_cur_ch), k);
            n = 0;
            while (!m_ppm && n < LIMIT) begin n++; @(negedge clk); end
            check("ch_low", n, PL);
            total += n;
            n = 0;
            while (m_ppm && n < LIMIT) begin n++; @(negedge clk); end
            check("ch_high", n, int'(e.w[k]) - PL);
            total += n;
        end
        n = 0;
        while (!m_ppm && n < LIMIT) begin n++; @(negedge clk); end
        check("end_low", n, PL);
        total += n;
        n = 0;
        done_seen = 1'b0;
        while (m_ppm && !done_seen && n < LIMIT) begin
            n++;
            done_seen = m_frame_done;
            @(negedge clk);
        end
        check("frame_done_seen", int'(done_seen), 1);
        check("sync_high", n, int'(e.g));
        total += n;
        check("period", total, int'(e.period));
        if (e.more) begin
            check("back_to_back_start", int'(m_frame_start), 1);
        end else begin
            check("after_pin", int'(m_ppm), 1);
            check("after_busy", int'(m_busy), 0);
        end
        if ($time == t0) @(negedge clk);
    endtask

    initial begin
        forever begin
            if (mon_en && m_frame_start) do_frame();
            else @(negedge clk);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int i;
        rst_n     = 1'b0;
        enable    = 1'b0;
        sw_mode   = 1'b1;
        sw_ch     = '0;
        cap_ch    = '0;
        cap_valid = 1'b0;
        sel       = 1'b0;
        mon_en    = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ppm", int'(ppm_a), 1);
        check("rst_busy", int'(busy_a), 0);
        check("rst_fs", int'(fs_a), 0);
        check("rst_fd", int'(fd_a), 0);
        check("rst_stale", int'(stale_a), 0);
        check("rst_cur_ch", int'(ch_a), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy_a), 0);

        // Nominal widths, then out-of-range widths that must clamp
        plan_q.push_back(mk_sw(12, 15, 18, 20));
        plan_q.push_back(mk_sw(5, 25, 10, 0));
        run_plan(1'b0);

        // Relay: one capture, then a frame without a fresh capture
        plan_q.push_back(mk_relay(1'b1, 1'b0, 11, 12, 13, 14));
        plan_q.push_back(mk_relay(1'b0, 1'b0, 0, 0, 0, 0));
        run_plan(1'b0);

        // Capture strobe in the latch cycle is used and does not linger
        plan_q.push_back(mk_relay(1'b0, 1'b1, 19, 3, 27, 15));
        plan_q.push_back(mk_relay(1'b0, 1'b0, 0, 0, 0, 0));
        run_plan(1'b0);

        // Enable dropped during channel 1 high time
        plan_q.push_back(mk_sw(16, 13, 17, 11));
        plan_q.push_back(mk_sw(14, 19, 12, 18));
        run_plan(1'b1);

        // Randomized frames
        for (int f = 0; f < 6; f++) plan_q.push_back(mk_rand());
        run_plan(1'b0);

        // Asynchronous reset during CH_LO, with a pending capture to discard
        mon_en  = 1'b0;
        sw_mode = 1'b1;
        sw_ch   = mk_sw(20, 20, 20, 20).sw;
        enable  = 1'b1;
        i = 0;
        while (ppm_a && i < LIMIT) begin @(negedge clk); i++; end
        check("reset_test_in_ch_lo", int'(ppm_a), 0);
        cap_ch    = mk_relay(1'b0, 1'b0, 17, 17, 17, 17).cap;
        sw_mode   = 1'b0;
        cap_valid = 1'b1;
        @(negedge clk);
        cap_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ppm", int'(ppm_a), 1);
        check("async_rst_busy", int'(busy_a), 0);
        check("async_rst_cur_ch", int'(ch_a), 0);
        check("async_rst_fs", int'(fs_a), 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        mon_en = 1'b1;
        plan_q.push_back(mk_relay(1'b0, 1'b0, 0, 0, 0, 0));
        plan_q.push_back(mk_sw(13, 20, 11, 16));
        run_plan(1'b0);

        // Short nominal period: sync gap floors at the minimum
        sel = 1'b1;
        @(negedge clk);
        plan_q.push_back(mk_sw(20, 20, 20, 20));
        plan_q.push_back(mk_sw(10, 10, 10, 10));
        plan_q.push_back(mk_rand());
        run_plan(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
